// File: rtl/fir_128_mdc_engine_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fir_128_mdc_engine_ctrl_if
// Brief    : Valid/ready stream bundle used on every engine stream port.
// Revision : 1.0
// ============================================================================
interface fir_128_mdc_engine_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface
`default_nettype wire

// File: rtl/fir_128_mdc_engine_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fir_128_mdc_engine_ctrl
// Brief    : Run controller for the FIR core: x pass-through, 2-deep y FIFO,
//            per-run sample counting and start/done sequencing.
// Revision : 1.0
// ============================================================================
module fir_128_mdc_engine_ctrl #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  wire logic             clk_i,
    input  wire logic             rst_ni,
    input  wire logic             clear_i,
    input  wire logic             eng_clear_i,
    input  wire logic             eng_enable_i,
    input  wire logic             eng_start_i,
    input  wire logic [CNT_W-1:0] cnt_limit_i,
    output logic                  ready_o,
    output logic                  done_o,
    output logic                  core_start_o,
    output logic      [CNT_W-1:0] cnt_y_o,
    fir_128_mdc_engine_ctrl_if.slave  x,
    fir_128_mdc_engine_ctrl_if.master core_x,
    fir_128_mdc_engine_ctrl_if.slave  core_y,
    fir_128_mdc_engine_ctrl_if.master y
);

    localparam logic [1:0]       S_IDLE = 2'd0;
    localparam logic [1:0]       S_RUN  = 2'd1;
    localparam logic [1:0]       S_DONE = 2'd2;
    localparam logic [CNT_W-1:0] C_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic [CNT_W-1:0]  r_limit;
    logic [CNT_W-1:0]  r_acc_cnt;
    logic [CNT_W-1:0]  r_cnt_y;
    logic [DATA_W-1:0] r_fifo_mem [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_fifo_cnt;

    logic w_clr, w_start, w_run_en, w_full, w_empty, w_push, w_pop, w_last_pop;

    assign w_clr    = clear_i | eng_clear_i;
    assign w_start  = (r_state == S_IDLE) & eng_start_i & eng_enable_i & ~w_clr;
    assign w_run_en = (r_state == S_RUN) & eng_enable_i;

    assign core_x.valid = x.valid & w_run_en;
    assign core_x.data  = x.data;
    assign x.ready      = core_x.ready & w_run_en;

    assign w_full      = (r_fifo_cnt == 2'd2);
    assign w_empty     = (r_fifo_cnt == 2'd0);
    // Pushes stop once the run has taken its full quota from the core.
    assign core_y.ready = w_run_en & ~w_full & (r_acc_cnt < r_limit);
    assign w_push       = core_y.valid & core_y.ready;
    assign y.valid      = ~w_empty;
    assign y.data       = r_fifo_mem[r_rd_ptr];
    assign w_pop        = y.valid & y.ready;
    assign w_last_pop   = w_pop & (r_cnt_y < r_limit) & ((r_cnt_y + C_ONE) == r_limit);
    assign cnt_y_o      = r_cnt_y;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (w_clr) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_start) w_state_next = (cnt_limit_i != '0) ? S_RUN : S_DONE;
                S_RUN:   if (w_last_pop) w_state_next = S_DONE;
                S_DONE:  w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        ready_o      = (r_state == S_IDLE);
        done_o       = (r_state == S_DONE);
        core_start_o = w_start;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_limit   <= '0;
            r_acc_cnt <= '0;
            r_cnt_y   <= '0;
        end else if (w_clr) begin
            r_acc_cnt <= '0;
            r_cnt_y   <= '0;
        end else if (w_start) begin
            r_limit   <= cnt_limit_i;
            r_acc_cnt <= '0;
            r_cnt_y   <= '0;
        end else begin
            if (w_push) r_acc_cnt <= r_acc_cnt + C_ONE;
            if (w_pop && (r_cnt_y < r_limit)) r_cnt_y <= r_cnt_y + C_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fifo_mem[0] <= '0;
            r_fifo_mem[1] <= '0;
            r_wr_ptr      <= 1'b0;
            r_rd_ptr      <= 1'b0;
            r_fifo_cnt    <= 2'd0;
        end else if (w_clr) begin
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_fifo_cnt <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_mem[r_wr_ptr] <= core_y.data;
                r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fir_128_mdc_engine_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_128_mdc_engine_ctrl
// Brief    : Directed self-checking bench for the FIR engine controller.
// Revision : 1.0
// ============================================================================
module tb_fir_128_mdc_engine_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        clear_i = 1'b0;
    logic        eng_clear_i = 1'b0;
    logic        eng_enable_i = 1'b1;
    logic        eng_start_i = 1'b0;
    logic [31:0] cnt_limit_i = '0;
    logic        ready_o, done_o, core_start_o;
    logic [31:0] cnt_y_o;
    int          errors = 0;
    int          checks = 0;

    fir_128_mdc_engine_ctrl_if #(.DATA_W(32)) x_if ();
    fir_128_mdc_engine_ctrl_if #(.DATA_W(32)) core_x_if ();
    fir_128_mdc_engine_ctrl_if #(.DATA_W(32)) core_y_if ();
    fir_128_mdc_engine_ctrl_if #(.DATA_W(32)) y_if ();

    fir_128_mdc_engine_ctrl #(.DATA_W(32), .CNT_W(32)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (clear_i),
        .eng_clear_i  (eng_clear_i),
        .eng_enable_i (eng_enable_i),
        .eng_start_i  (eng_start_i),
        .cnt_limit_i  (cnt_limit_i),
        .ready_o      (ready_o),
        .done_o       (done_o),
        .core_start_o (core_start_o),
        .cnt_y_o      (cnt_y_o),
        .x            (x_if),
        .core_x       (core_x_if),
        .core_y       (core_y_if),
        .y            (y_if)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_run(input logic [31:0] lim);
        cnt_limit_i = lim;
        eng_start_i = 1'b1;
        #1;
        chk("start_pulse", core_start_o, 1);
        chk("start_ready", ready_o, 1);
        tick();
        eng_start_i = 1'b0;
    endtask

    // Streams core samples base+k, checks ordering and counts until done_o.
    task automatic run_stream(input logic [31:0] base, input int n_offer, input int lim,
                              input int sent0, input int got0,
                              input int stall_from, input int stall_len);
        int sent = sent0;
        int got = got0;
        int cyc = 0;
        int last_pop = -10;
        bit seen = 1'b0;
        while (!seen && cyc < 200) begin
            core_y_if.valid = (sent < n_offer);
            core_y_if.data  = base + sent;
            y_if.ready      = !(cyc >= stall_from && cyc < stall_from + stall_len);
            #1;
            if (done_o) begin
                seen = 1'b1;
                chk("done_latency", cyc, last_pop + 1);
                chk("done_cnt_y", cnt_y_o, lim);
                chk("done_y_valid", y_if.valid, 0);
            end else begin
                chk("run_ready", ready_o, 0);
                chk("run_cnt_y", cnt_y_o, got);
                if (sent >= lim) chk("acc_sat_ready", core_y_if.ready, 0);
                if (cyc > stall_from && cyc < stall_from + stall_len) begin
                    chk("stall_core_ready", core_y_if.ready, 0);
                    chk("stall_valid", y_if.valid, 1);
                    chk("stall_hold", y_if.data, base + got);
                end
                if (core_y_if.valid && core_y_if.ready) sent++;
                if (y_if.valid && y_if.ready) begin
                    chk("y_order", y_if.data, base + got);
                    got++;
                    last_pop = cyc;
                end
                cyc++;
                tick();
            end
        end
        chk("run_timeout", seen, 1);
        chk("accepted", sent, lim);
        chk("delivered", got, lim);
        core_y_if.valid = 1'b0;
        y_if.ready      = 1'b1;
        tick();
        chk("post_ready", ready_o, 1);
        chk("post_done", done_o, 0);
    endtask

    initial begin
        x_if.valid = 1'b0; x_if.data = '0;
        core_x_if.ready = 1'b0;
        core_y_if.valid = 1'b0; core_y_if.data = '0;
        y_if.ready = 1'b1;

        #2;
        chk("rst_ready", ready_o, 1);
        chk("rst_done", done_o, 0);
        chk("rst_start", core_start_o, 0);
        chk("rst_y_valid", y_if.valid, 0);
        chk("rst_cnt_y", cnt_y_o, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();

        // limit 4, sink always ready, plus x path and ignored start in RUN
        start_run(32'd4);
        eng_start_i = 1'b1;
        x_if.valid = 1'b1; x_if.data = 32'h1234_5678; core_x_if.ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            core_y_if.valid = 1'b1;
            core_y_if.data  = 32'hA000_0000 + i;
            #1;
            chk("t1_core_y_ready", core_y_if.ready, 1);
            chk("t1_ready", ready_o, 0);
            if (i == 0) begin
                chk("t1_start_ignored", core_start_o, 0);
                chk("t1_core_x_valid", core_x_if.valid, 1);
                chk("t1_x_ready", x_if.ready, 1);
                chk("t1_core_x_data", core_x_if.data, 32'h1234_5678);
                eng_start_i = 1'b0;
            end else begin
                chk("t1_y_valid", y_if.valid, 1);
                chk("t1_y_data", y_if.data, 32'hA000_0000 + i - 1);
                chk("t1_cnt_y", cnt_y_o, i - 1);
            end
            tick();
        end
        core_y_if.valid = 1'b0;
        #1;
        chk("t1_core_y_ready_sat", core_y_if.ready, 0);
        chk("t1_y_data_last", y_if.data, 32'hA000_0003);
        chk("t1_cnt_y_3", cnt_y_o, 3);
        tick();
        chk("t1_done", done_o, 1);
        chk("t1_cnt_y_4", cnt_y_o, 4);
        chk("t1_done_ready", ready_o, 0);
        tick();
        chk("t1_idle_ready", ready_o, 1);
        chk("t1_idle_done", done_o, 0);
        chk("t1_idle_x_gated", core_x_if.valid, 0);
        x_if.valid = 1'b0; core_x_if.ready = 1'b0;

        // limit 8 with a 5-cycle sink stall; limit input changed mid-run
        start_run(32'd8);
        cnt_limit_i = 32'd1;
        run_stream(32'hB000_0000, 8, 8, 0, 0, 2, 5);

        // enable low for 3 cycles with one sample pending in the FIFO
        start_run(32'd4);
        core_y_if.valid = 1'b1; core_y_if.data = 32'hC000_0000;
        y_if.ready = 1'b0;
        tick();
        eng_enable_i = 1'b0;
        x_if.valid = 1'b1; core_x_if.ready = 1'b1;
        core_y_if.data = 32'hC000_0001;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t3_x_ready", x_if.ready, 0);
            chk("t3_core_x_valid", core_x_if.valid, 0);
            chk("t3_core_y_ready", core_y_if.ready, 0);
            chk("t3_y_valid", y_if.valid, 1);
            chk("t3_y_data", y_if.data, 32'hC000_0000);
            chk("t3_cnt_y", cnt_y_o, 0);
            tick();
        end
        eng_enable_i = 1'b1;
        x_if.valid = 1'b0; core_x_if.ready = 1'b0;
        run_stream(32'hC000_0000, 4, 4, 1, 0, 0, 0);

        // limit 0 goes straight to DONE
        start_run(32'd0);
        chk("t4_done", done_o, 1);
        chk("t4_cnt_y", cnt_y_o, 0);
        chk("t4_ready", ready_o, 0);
        tick();
        chk("t4_idle", ready_o, 1);
        chk("t4_done_off", done_o, 0);

        // limit 3, core offers 5
        start_run(32'd3);
        run_stream(32'hD000_0000, 5, 3, 0, 0, 0, 0);

        // engine clear after 2 of 6 samples, then a normal limit-2 run
        start_run(32'd6);
        for (int i = 0; i < 3; i++) begin
            core_y_if.valid = 1'b1;
            core_y_if.data  = 32'hE000_0000 + i;
            tick();
        end
        core_y_if.valid = 1'b0;
        #1;
        chk("t6_cnt_y_2", cnt_y_o, 2);
        chk("t6_y_valid", y_if.valid, 1);
        chk("t6_y_data", y_if.data, 32'hE000_0002);
        eng_clear_i = 1'b1;
        tick();
        eng_clear_i = 1'b0;
        #1;
        chk("t6_ready", ready_o, 1);
        chk("t6_cnt_y_0", cnt_y_o, 0);
        chk("t6_y_valid_0", y_if.valid, 0);
        chk("t6_no_done", done_o, 0);
        tick();
        chk("t6_no_done_2", done_o, 0);
        start_run(32'd2);
        run_stream(32'hF000_0000, 2, 2, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
